// File: rtl/shift_issue_seq.sv
// shift_issue_seq: command sequencer in front of the combinational barrel shifter
// Ports: in_valid/in_ready/in_a/in_b/in_op command handshake; sh_a/sh_b/sh_cntrl drive the
// shifter and sh_y returns its result; out_valid/out_ready/out_y/out_zero/out_err result handshake.
// Optional feature macro: SHIFT_ROTATE_EN (op 11 = rotate right via two shifter passes).
module shift_issue_seq #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic [1:0]   in_op,
   output logic [W-1:0] sh_a,
   output logic [W-1:0] sh_b,
   output logic [1:0]   sh_cntrl,
   input  logic [W-1:0] sh_y,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_y,
   output logic         out_zero,
   output logic         out_err
);
   localparam logic [1:0] IDLE = 2'd0, PASS1 = 2'd1, PASS2 = 2'd2, DONE = 2'd3;
   logic [1:0]   state_q, state_d, op_q, op_d, sh_cntrl_q, sh_cntrl_d;
   logic [W-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d, out_y_q, out_y_d, sat_y;
   logic         out_zero_q, out_zero_d, out_err_q, out_err_d, accept;
`ifdef SHIFT_ROTATE_EN
   logic [W-1:0] part_q, part_d;
`endif
   always_comb begin
      in_ready   = (state_q == IDLE) || (state_q == DONE && out_ready);
      accept     = in_valid && in_ready;
      state_d    = state_q;
      op_d       = op_q;
      sh_a_d     = sh_a_q;
      sh_b_d     = sh_b_q;
      sh_cntrl_d = sh_cntrl_q;
      out_y_d    = out_y_q;
      out_zero_d = out_zero_q;
      out_err_d  = out_err_q;
`ifdef SHIFT_ROTATE_EN
      part_d     = part_q;
`endif
      // sh_b still holds the full command amount during PASS1 of a plain shift
      sat_y      = (op_q == 2'b10) ? {W{sh_a_q[W-1]}} : '0;
      if (accept) begin
         state_d    = PASS1;
         op_d       = in_op;
         sh_a_d     = in_a;
         sh_b_d     = in_b;
         sh_cntrl_d = (in_op == 2'b11) ? 2'b01 : in_op;
`ifdef SHIFT_ROTATE_EN
         if (in_op == 2'b11) sh_b_d = {{(W-5){1'b0}}, in_b[4:0]};
`endif
      end else if (state_q == PASS1) begin
         state_d   = DONE;
         out_err_d = 1'b0;
         out_y_d   = (|sh_b_q[W-1:5]) ? sat_y : sh_y;
         if (op_q == 2'b11) begin
`ifdef SHIFT_ROTATE_EN
            // second pass: left shift by the complementary amount, ORed with this partial
            state_d    = PASS2;
            part_d     = sh_y;
            sh_cntrl_d = 2'b00;
            sh_b_d     = {{(W-5){1'b0}}, 5'd0 - sh_b_q[4:0]};
            out_y_d    = out_y_q;
            out_err_d  = out_err_q;
`else
            out_y_d   = '0;
            out_err_d = 1'b1;
`endif
         end
`ifdef SHIFT_ROTATE_EN
      end else if (state_q == PASS2) begin
         state_d   = DONE;
         out_y_d   = part_q | sh_y;
         out_err_d = 1'b0;
`endif
      end else if (state_q == DONE && out_ready) begin
         state_d = IDLE;
      end
      if (state_d == DONE && state_q != DONE) out_zero_d = (out_y_d == '0);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         op_q       <= 2'b00;
         sh_a_q     <= '0;
         sh_b_q     <= '0;
         sh_cntrl_q <= 2'b01;
         out_y_q    <= '0;
         out_zero_q <= 1'b0;
         out_err_q  <= 1'b0;
`ifdef SHIFT_ROTATE_EN
         part_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         sh_a_q     <= sh_a_d;
         sh_b_q     <= sh_b_d;
         sh_cntrl_q <= sh_cntrl_d;
         out_y_q    <= out_y_d;
         out_zero_q <= out_zero_d;
         out_err_q  <= out_err_d;
`ifdef SHIFT_ROTATE_EN
         part_q     <= part_d;
`endif
      end
   end
   assign sh_a      = sh_a_q;
   assign sh_b      = sh_b_q;
   assign sh_cntrl  = sh_cntrl_q;
   assign out_valid = (state_q == DONE);
   assign out_y     = out_y_q;
   assign out_zero  = out_zero_q;
   assign out_err   = out_err_q;
endmodule

// File: tb/tb_shift_issue_seq.sv
// tb_shift_issue_seq: directed bench with a shifter model and a result scoreboard
module tb_shift_issue_seq;
   logic        clk = 1'b0, rst, in_valid, in_ready, out_valid, out_ready, out_zero, out_err;
   logic [31:0] in_a, in_b, sh_a, sh_b, sh_y, out_y;
   logic [1:0]  in_op, sh_cntrl;
   int vectors = 0, miscompares = 0, cyc = 0;
   typedef struct { logic [31:0] y; logic z; logic e; } res_t;
   res_t q[$];
   int pops[$];
   logic hold = 1'b0;
   logic [31:0] hy;
   logic hz, he;

   shift_issue_seq #(.W(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .in_op(in_op), .sh_a(sh_a), .sh_b(sh_b), .sh_cntrl(sh_cntrl), .sh_y(sh_y),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_zero(out_zero), .out_err(out_err)
   );

   always #5 clk = ~clk;

   // external combinational barrel shifter
   always_comb begin
      sh_y = 32'hDEAD_BEEF;
      if (sh_cntrl == 2'b00) sh_y = sh_a << sh_b[4:0];
      else if (sh_cntrl == 2'b01) sh_y = sh_a >> sh_b[4:0];
      else if (sh_cntrl == 2'b10) sh_y = $unsigned($signed(sh_a) >>> sh_b[4:0]);
   end

   function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      res_t r;
      int unsigned n;
      n = b;
      r.e = 1'b0;
      if (op == 2'b00) r.y = (n >= 32) ? 32'd0 : a << n;
      else if (op == 2'b01) r.y = (n >= 32) ? 32'd0 : a >> n;
      else if (op == 2'b10) r.y = (n >= 32) ? {32{a[31]}} : $unsigned($signed(a) >>> n);
      else begin
`ifdef SHIFT_ROTATE_EN
         n = n % 32;
         r.y = (n == 0) ? a : ((a >> n) | (a << (32 - n)));
`else
         r.y = 32'd0;
         r.e = 1'b1;
`endif
      end
      r.z = (r.y == 32'd0);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      res_t r;
      cyc++;
      if (rst) begin
         q.delete();
         hold = 1'b0;
      end else begin
         chk("sh_cntrl_legal", {31'd0, sh_cntrl != 2'b11}, 32'd1);
         if (hold) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_y", out_y, hy);
            chk("hold_flags", {30'd0, out_zero, out_err}, {30'd0, hz, he});
         end
         if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_op));
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_result", out_y, 32'hXXXX_XXXX);
            else begin
               r = q.pop_front();
               chk("sb_y", out_y, r.y);
               chk("sb_zero", {31'd0, out_zero}, {31'd0, r.z});
               chk("sb_err", {31'd0, out_err}, {31'd0, r.e});
               pops.push_back(cyc);
            end
         end
         hold = out_valid && !out_ready;
         hy = out_y;
         hz = out_zero;
         he = out_err;
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      int n = 0;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      in_op = op;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic get_result(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 20);
      if (!out_valid) chk("result_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1);
   end

   initial begin
      int lat;
      logic [31:0] va [8] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h7FFF_FFFF,
                              32'h8000_0000, 32'h1234_5678, 32'h8765_4321, 32'h0000_0001};
      logic [31:0] vb [8] = '{32'd0, 32'd31, 32'd32, 32'd31, 32'hFFFF_FFFF, 32'd36, 32'd5, 32'd1};
      logic [1:0]  vo [8] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd1};
      rst = 1'b1;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      in_op = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_y", out_y, 32'd0);
      chk("rst_flags", {30'd0, out_zero, out_err}, 32'd0);
      chk("rst_sh_a", sh_a, 32'd0);
      chk("rst_sh_b", sh_b, 32'd0);
      chk("rst_sh_cntrl", {30'd0, sh_cntrl}, 32'd1);
      @(posedge clk);
      #1 rst = 1'b0;

      send(32'h0000_00F1, 32'd4, 2'b00);
      get_result(lat);
      chk("sll_latency", lat, 32'd2);
      chk("sll_y", out_y, 32'h0000_0F10);
      chk("sll_flags", {30'd0, out_zero, out_err}, 32'd0);

      send(32'h8000_0000, 32'd31, 2'b10);
      get_result(lat);
      chk("sra31_y", out_y, 32'hFFFF_FFFF);
      send(32'h8000_0000, 32'd40, 2'b10);
      get_result(lat);
      chk("sra40_y", out_y, 32'hFFFF_FFFF);
      send(32'h8000_0000, 32'd40, 2'b01);
      get_result(lat);
      chk("srl40_y", out_y, 32'h0000_0000);
      chk("srl40_zero", {31'd0, out_zero}, 32'd1);

      @(posedge clk);
      #1 out_ready = 1'b0;
      send(32'h1234_5678, 32'd0, 2'b01);
      get_result(lat);
      repeat (5) begin
         @(negedge clk);
         chk("stall_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_y", out_y, 32'h1234_5678);
         chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);

      pops.delete();
      send(32'h0000_0001, 32'd1, 2'b00);
      send(32'hFFFF_0000, 32'd8, 2'b01);
      send(32'h8000_0001, 32'd3, 2'b10);
      send(32'hA5A5_A5A5, 32'd33, 2'b00);
      drain();
      chk("b2b_count", 32'(pops.size()), 32'd4);
      for (int i = 1; i < pops.size(); i++) chk("b2b_slot", 32'(pops[i] - pops[i-1]), 32'd2);

      send(32'h0000_000F, 32'd4, 2'b11);
      get_result(lat);
`ifdef SHIFT_ROTATE_EN
      chk("rot_latency", lat, 32'd3);
      chk("rot_y", out_y, 32'hF000_0000);
      chk("rot_err", {31'd0, out_err}, 32'd0);
      send(32'h0000_000F, 32'd0, 2'b11);
      get_result(lat);
      chk("rot0_y", out_y, 32'h0000_000F);
`else
      chk("ill_latency", lat, 32'd2);
      chk("ill_y", out_y, 32'd0);
      chk("ill_err", {31'd0, out_err}, 32'd1);
`endif

      for (int i = 0; i < 8; i++) send(va[i], vb[i], vo[i]);
      drain();

      send(32'h0000_0055, 32'd2, 2'b00);
      #3;
      chk("pass1_in_ready", {31'd0, in_ready}, 32'd0);
      rst = 1'b1;
      #1;
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("arst_out_y", out_y, 32'd0);
      chk("arst_sh_cntrl", {30'd0, sh_cntrl}, 32'd1);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("no_stale_valid", {31'd0, out_valid}, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
